seg_capture: RTL
================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical samples required before a digit is captured; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seg  input  7  segment levels, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 dig_en  input  4  digit strobes, active-high; exactly one bit set selects digit k (k = bit index).
REQ-006 clear  input  1  synchronous abort of the frame in progress.
REQ-007 frame_value  output  16  last complete frame; digit k occupies bits [4k+3:4k].
REQ-008 frame_valid  output  1  one-cycle pulse when frame_value is updated.
REQ-009 digit_valid  output  4  bit k set once digit k of the current frame has been captured.
REQ-010 pat_err  output  1  one-cycle pulse when a captured pattern is not in the decode table.
REQ-011 err_digit  output  2  index of the digit that caused the most recent pat_err; holds until the next error.

Function
REQ-012 Decode table, {a..g} -> nibble: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=B, 1001110=C, 0111101=D, 1001111=E, 1000111=F; any other pattern is invalid.
REQ-013 {dig_en, seg} is registered into an 11-bit sample register on every edge; no logic acts on the raw inputs directly.
REQ-014 Two-state FSM: SETTLE (counting) and HELD (digit captured, awaiting change).
REQ-015 Stability counter: 8 bits; cleared to 0 on any edge where the new sample differs from the sample register; otherwise incremented, saturating at STABLE_CYCLES.
REQ-016 In SETTLE, the edge on which the counter reaches STABLE_CYCLES is the capture edge; the FSM moves to HELD on that edge.
REQ-017 In HELD, no further capture occurs; any change of sample returns the FSM to SETTLE with counter 0.
REQ-018 Capture is suppressed, and the FSM stays in SETTLE, while the sampled dig_en is not one-hot (0000 or more than one bit set).
REQ-019 Latency: with inputs steady from before edge 1 and the sample register differing before it, capture happens on edge STABLE_CYCLES+1; with the default that is edge 5.
REQ-020 Valid capture of digit k writes the decoded nibble into an internal working register at [4k+3:4k] and sets digit_valid[k]; recapturing a digit that is already valid overwrites its nibble.
REQ-021 Invalid capture of digit k pulses pat_err for one cycle, loads err_digit=k and clears digit_valid[k]; the working nibble is unchanged.
REQ-022 Frame completion: when a capture makes digit_valid equal 1111, on the next edge frame_value loads the working register, frame_valid pulses for one cycle, and digit_valid returns to 0000.
REQ-023 clear asserted: on that edge digit_valid=0000, the working register is 0, the FSM returns to SETTLE and the counter is 0; frame_value and err_digit are kept.
REQ-024 clear coincident with a capture: clear wins, and no digit_valid, pat_err or frame update results.
REQ-025 clear coincident with a pending frame_valid: the frame pulse still occurs with the completed value, and digit_valid ends at 0000.
REQ-026 The sample register wraps nothing; the saturated counter never rolls over, however long the input is held.

Reset
REQ-027 While rst_n=0: frame_value=0000h, frame_valid=0, digit_valid=0000, pat_err=0, err_digit=0, working register=0, sample register=0, counter=0, FSM=SETTLE.
REQ-028 rst_n asserted mid-capture or mid-frame discards all partial state immediately; after release, the first capture needs the full STABLE_CYCLES sequence again.

Verification
REQ-029 dig_en=0001, seg=0110000 held 6 cycles -> digit_valid=0001 after edge 5, one capture only, no pat_err.
REQ-030 Scan digits 0..3 with 1111001, 1001110, 1111111, 1000111, each held 6 cycles -> frame_value=F8C3h, single frame_valid pulse one edge after the digit-3 capture, then digit_valid=0000.
REQ-031 dig_en=0100, seg=1010101 held 6 cycles -> pat_err pulses once, err_digit=2, digit_valid[2]=0.
REQ-032 seg toggles between two patterns every 3 cycles with STABLE_CYCLES=4 -> no capture; dig_en=0011 held steady -> no capture.
REQ-033 clear asserted on the capture edge of digit 1 -> digit_valid=0000, frame_value unchanged; rst_n pulsed low mid-frame -> every output at its reset value asynchronously.

Source files
------------

// File: rtl/seg_capture_if.sv
// Bus bundle for the seven-segment capture block.
// The bench drives through the master modport; seg_capture uses the slave modport.
interface seg_capture_if;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        clear;
  logic [15:0] frame_value;
  logic        frame_valid;
  logic [3:0]  digit_valid;
  logic        pat_err;
  logic [1:0]  err_digit;

  modport master (
    output seg, dig_en, clear,
    input  frame_value, frame_valid, digit_valid, pat_err, err_digit
  );

  modport slave (
    input  seg, dig_en, clear,
    output frame_value, frame_valid, digit_valid, pat_err, err_digit
  );
endinterface

// File: rtl/seg_capture.sv
// Seven-segment display scan capture.
// Samples the multiplexed segment/digit-strobe lines and waits for them to
// settle. It decodes each settled digit to a nibble and assembles four
// digits into a 16-bit frame.
//
// state  | meaning
// SETTLE | sample changing or not yet stable long enough; counting
// HELD   | digit captured for the current sample; waiting for a change
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  seg_capture_if.slave bus
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {SETTLE, HELD} state_t;

  state_t      state, state_nxt;
  logic [10:0] samp;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] work;
  logic [15:0] frame_value;
  logic        frame_valid;
  logic [3:0]  digit_valid;
  logic        pat_err;
  logic [1:0]  err_digit;
  logic        frame_pend;

  logic [10:0] raw;
  logic        same;
  logic        onehot;
  logic [1:0]  idx;
  logic        capture;
  logic [4:0]  dec;
  logic [3:0]  dv_set;

  assign raw = {bus.dig_en, bus.seg};

  // Decode {a..g} into {valid, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // Stability tracking, digit selection and FSM next state.
  always_comb begin
    same      = (raw == samp);
    onehot    = 1'b1;
    idx       = 2'd0;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    state_nxt = state;
    dec       = decode(samp[6:0]);

    case (samp[10:7])
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: onehot = 1'b0;
    endcase

    dv_set = digit_valid | (4'b0001 << idx);

    if (bus.clear || !same) begin
      cnt_nxt = 8'd0;
    end else if (cnt != STABLE) begin
      cnt_nxt = cnt + 8'd1;
    end

    // Capture only on the edge where the count first reaches the threshold.
    if (state == SETTLE && same && onehot && !bus.clear &&
        cnt_nxt == STABLE && cnt != STABLE) begin
      capture = 1'b1;
    end

    case (state)
      SETTLE: if (capture) state_nxt = HELD;
      HELD:   if (!same) state_nxt = SETTLE;
      default: state_nxt = SETTLE;
    endcase

    if (bus.clear) state_nxt = SETTLE;
  end

  // FSM state, sample register and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      samp  <= 11'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      samp  <= raw;
      cnt   <= cnt_nxt;
    end
  end

  // Working register, per-digit valid flags, error reporting and frame output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work        <= 16'd0;
      frame_value <= 16'd0;
      frame_valid <= 1'b0;
      digit_valid <= 4'd0;
      pat_err     <= 1'b0;
      err_digit   <= 2'd0;
      frame_pend  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      // A completed frame is published even if clear arrives on the same edge.
      if (frame_pend) begin
        frame_value <= work;
        frame_valid <= 1'b1;
      end
      if (bus.clear) begin
        work        <= 16'd0;
        digit_valid <= 4'd0;
        frame_pend  <= 1'b0;
      end else if (frame_pend) begin
        digit_valid <= 4'd0;
        frame_pend  <= 1'b0;
      end else if (capture) begin
        if (dec[4]) begin
          work[{idx, 2'b00} +: 4] <= dec[3:0];
          digit_valid             <= dv_set;
          frame_pend              <= (dv_set == 4'hF);
        end else begin
          pat_err          <= 1'b1;
          err_digit        <= idx;
          digit_valid[idx] <= 1'b0;
        end
      end
    end
  end

  assign bus.frame_value = frame_value;
  assign bus.frame_valid = frame_valid;
  assign bus.digit_valid = digit_valid;
  assign bus.pat_err     = pat_err;
  assign bus.err_digit   = err_digit;

endmodule
